// File: rtl/bcd_updown_scan_display_pkg.sv
// Shared segment constants and BCD digit type for the scan display.
// Used by bcd_updown_scan_display and seg7_decode.
package bcd_disp_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic bcd_t bcd_clamp(input bcd_t d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/bcd_updown_scan_display_if.sv
// Control/data bundle of the BCD counter and scan display.
// master = board side (drives controls), slave = display block.
interface bcd_updown_scan_display_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count;
    logic                  wrap;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     dig_sel;

    modport master (
        output en, up, load, load_val,
        input  count, wrap, seg, dig_sel
    );

    modport slave (
        input  en, up, load, load_val,
        output count, wrap, seg, dig_sel
    );
endinterface

// File: rtl/bcd_updown_scan_display_seg7_decode.sv
// Combinational BCD digit to 7-segment lookup.
// Values above 9 decode to blank.
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  bcd_t       d,
    output logic [6:0] seg
);
    // digit lookup, blank for non-BCD codes
    always_comb begin
        seg = SEG_BLANK;
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/bcd_updown_scan_display.sv
// Multi-digit BCD up/down counter with load, wrap flag and 7-seg scan.
// Optional macro BCD_SCAN_LZ_BLANK_EN enables leading-zero blanking.
module bcd_updown_scan_display
    import bcd_disp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    bcd_updown_scan_display_if.slave bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

    logic [4*DIGITS-1:0] cnt_q, cnt_n;
    logic                wrap_q, wrap_n;
    logic                carry;
    logic [PW-1:0]       pre_q;
    logic [IW-1:0]       idx_q, idx_n;
    logic                adv;
    logic [DIGITS-1:0]   sel_q;
    logic [6:0]          seg_q, seg_n;
    bcd_t                digs [DIGITS];
    bcd_t                dec_in;
    logic                blank;

    // next count: load clamps, otherwise ripple carry/borrow across digits
    always_comb begin
        cnt_n  = cnt_q;
        wrap_n = 1'b0;
        carry  = 1'b1;
        if (bus.load) begin
            for (int i = 0; i < DIGITS; i++)
                cnt_n[4*i +: 4] = bcd_clamp(bus.load_val[4*i +: 4]);
        end else if (bus.en) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (bus.up) begin
                        if (cnt_q[4*i +: 4] == 4'd9) begin
                            cnt_n[4*i +: 4] = 4'd0;
                        end else begin
                            cnt_n[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                            carry = 1'b0;
                        end
                    end else begin
                        if (cnt_q[4*i +: 4] == 4'd0) begin
                            cnt_n[4*i +: 4] = 4'd9;
                        end else begin
                            cnt_n[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
                            carry = 1'b0;
                        end
                    end
                end
            end
            wrap_n = carry;
        end
    end

    // counter and wrap registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_n;
            wrap_q <= wrap_n;
        end
    end

    // scan index advances on the last prescaler count
    always_comb begin
        adv   = (pre_q == PMAX);
        idx_n = idx_q;
        if (adv)
            idx_n = (idx_q == LAST) ? '0 : idx_q + IW'(1);
    end

    // digit selected on this edge, optionally blanked as a leading zero
    always_comb begin
        for (int i = 0; i < DIGITS; i++)
            digs[i] = cnt_q[4*i +: 4];
`ifdef BCD_SCAN_LZ_BLANK_EN
        begin : lz
            logic [DIGITS:0] zabove;
            zabove[DIGITS] = 1'b1;
            for (int i = DIGITS - 1; i >= 0; i--)
                zabove[i] = zabove[i+1] && (digs[i] == 4'd0);
            blank = (idx_n != '0) && zabove[idx_n];
        end
`else
        blank = 1'b0;
`endif
        dec_in = blank ? 4'hF : digs[idx_n];
    end

    seg7_decode u_dec (
        .d   (dec_in),
        .seg (seg_n)
    );

    // prescaler, scan index and registered segment/digit outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
            sel_q <= DIGITS'(1);
            seg_q <= SEG_0;
        end else begin
            pre_q <= adv ? '0 : pre_q + PW'(1);
            idx_q <= idx_n;
            sel_q <= DIGITS'(1) << idx_n;
            seg_q <= seg_n;
        end
    end

    assign bus.count   = cnt_q;
    assign bus.wrap    = wrap_q;
    assign bus.seg     = seg_q;
    assign bus.dig_sel = sel_q;

endmodule

// File: tb/tb_bcd_updown_scan_display.sv
// Self-checking bench for bcd_updown_scan_display (DIGITS=4, SCAN_DIV=4).
// Table of count vectors plus scan, blanking and async-reset sequences.
module tb_bcd_updown_scan_display;

    localparam int D = 4;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    bcd_updown_scan_display_if #(.DIGITS(D)) bus ();

    bcd_updown_scan_display #(.DIGITS(D), .SCAN_DIV(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        load;
        logic        en;
        logic        up;
        logic [15:0] lv;
        logic [15:0] ecount;
        logic        ewrap;
        string       name;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] segof(input logic [3:0] d);
        logic [6:0] t [10];
        t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
        return (d > 4'd9) ? 7'b0000000 : t[d];
    endfunction

    initial begin
        vecs[0]  = '{1, 0, 1, 16'h9998, 16'h9998, 0, "load9998"};
        vecs[1]  = '{0, 1, 1, 16'h0000, 16'h9999, 0, "up9999"};
        vecs[2]  = '{0, 1, 1, 16'h0000, 16'h0000, 1, "upwrap"};
        vecs[3]  = '{0, 1, 1, 16'h0000, 16'h0001, 0, "up0001"};
        vecs[4]  = '{0, 0, 1, 16'h0000, 16'h0001, 0, "hold"};
        vecs[5]  = '{1, 0, 0, 16'h0001, 16'h0001, 0, "load0001"};
        vecs[6]  = '{0, 1, 0, 16'h0000, 16'h0000, 0, "dn0000"};
        vecs[7]  = '{0, 1, 0, 16'h0000, 16'h9999, 1, "dnwrap"};
        vecs[8]  = '{1, 0, 0, 16'h0100, 16'h0100, 0, "load0100"};
        vecs[9]  = '{0, 1, 0, 16'h0000, 16'h0099, 0, "dnborrow"};
        vecs[10] = '{1, 1, 1, 16'hF3A2, 16'h9392, 0, "loadclamp"};
        vecs[11] = '{0, 1, 1, 16'h0000, 16'h9393, 0, "up9393"};
        vecs[12] = '{0, 1, 0, 16'h0000, 16'h9392, 0, "dirchange"};
        vecs[13] = '{1, 0, 0, 16'h0070, 16'h0070, 0, "load0070"};

        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.up       = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_wrap", 32'(bus.wrap), 32'h0);
        chk("rst_digsel", 32'(bus.dig_sel), 32'h1);
        chk("rst_seg", 32'(bus.seg), 32'h7E);

        repeat (3) @(negedge clk);
        chk("scan_hold3", 32'(bus.dig_sel), 32'h1);
        @(negedge clk);
        chk("scan_adv4", 32'(bus.dig_sel), 32'h2);
        repeat (11) @(negedge clk);
        chk("scan_d3", 32'(bus.dig_sel), 32'h8);
        @(negedge clk);
        chk("scan_ret16", 32'(bus.dig_sel), 32'h1);

        for (int i = 0; i < 14; i++) begin
            bus.load     = vecs[i].load;
            bus.en       = vecs[i].en;
            bus.up       = vecs[i].up;
            bus.load_val = vecs[i].lv;
            @(negedge clk);
            chk({vecs[i].name, "_count"}, 32'(bus.count),
                32'(vecs[i].ecount));
            chk({vecs[i].name, "_wrap"}, 32'(bus.wrap),
                32'(vecs[i].ewrap));
        end
        bus.load = 1'b0;
        bus.en   = 1'b0;

        // count now 0070; seg must track the selected digit
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            logic [6:0] e;
            @(negedge clk);
            unique case (bus.dig_sel)
                4'b0001: e = segof(4'd0);
                4'b0010: e = segof(4'd7);
`ifdef BCD_SCAN_LZ_BLANK_EN
                4'b0100: e = 7'b0000000;
                4'b1000: e = 7'b0000000;
`else
                4'b0100: e = segof(4'd0);
                4'b1000: e = segof(4'd0);
`endif
                default: e = 7'bxxxxxxx;
            endcase
            chk($sformatf("seg_sel%h", bus.dig_sel), 32'(bus.seg), 32'(e));
        end

        // run a few steps, then drop reset between edges
        bus.en = 1'b1;
        bus.up = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_rst_count", 32'(bus.count), 32'h0075);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(bus.count), 32'h0);
        chk("arst_wrap", 32'(bus.wrap), 32'h0);
        chk("arst_digsel", 32'(bus.dig_sel), 32'h1);
        chk("arst_seg", 32'(bus.seg), 32'h7E);
        bus.en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_count", 32'(bus.count), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_updown_scan_display.md
# bcd_updown_scan_display

- Parametrised DIGITS-wide decimal up/down counter with load, wrap flag and a time-multiplexed 7-segment scan driver.
- Successor to the single-digit BCD-to-segment decode used on the lab boards. Adds multi-digit BCD counting, synchronous load and digit scanning.
- Sits between the board tick generator (the `en` pulse) and the common-cathode segment/digit pins.

## Interface
Parameters:
- DIGITS, 4: number of BCD digits (1–8); digit 0 is least significant.
- SCAN_DIV, 1000: clk cycles each digit stays selected (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count-step qualifier; one step per clk cycle it is high.
- up  input  1  1 = count up, 0 = count down; sampled with en.
- load  input  1  synchronous load; has priority over en.
- load_val  input  4*DIGITS  BCD load value; nibble i goes to digit i.
- count  output  4*DIGITS  registered BCD count.
- wrap  output  1  one-cycle pulse on full-range rollover.
- seg  output  7  segments {a,b,c,d,e,f,g}, bit6 = a, active high.
- dig_sel  output  DIGITS  one-hot digit enable, active high.

## Operation
- Counter update priority per clk: load > en > hold.
- **Load:** count ← load_val. Any nibble >9 is clamped to 9. wrap = 0.
- **en && up:** BCD increment. A digit at 9 becomes 0 and carries into the next digit. All digits at 9 become all 0 and wrap = 1 for that cycle.
- **en && !up:** BCD decrement. A digit at 0 becomes 9 and borrows from the next digit. All digits at 0 become all 9 and wrap = 1 for that cycle.
- **Otherwise:** count holds and wrap = 0.
- **Scan:**
  - Prescaler runs 0..SCAN_DIV-1 continuously, independent of en/load.
  - When it reaches SCAN_DIV-1, the digit index advances i → (i+1) mod DIGITS.
  - dig_sel = 1 << i.
- **Segment patterns:** 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011. Any other value → 0000000 (blank, never X).
- **Reset values:** count = 0, wrap = 0, prescaler = 0, index = 0, dig_sel = 1 (digit 0), seg = 1111110.

## Timing
- count and wrap change on the clk edge that samples load/en. Latency: 1 cycle.
- seg and dig_sel are both registered and always change on the same edge, so they stay mutually consistent.
- seg shows the digit currently selected by dig_sel, using the count value from the previous cycle. A count change therefore appears on seg at most 1 cycle later.
- Back-to-back en (tied high) steps every cycle. wrap pulses exactly on the rollover edge.
- load and en in the same cycle: load wins, no step, wrap = 0.
- Changing up between cycles takes effect on the next en. No hysteresis.
- Reset assertion mid-scan or mid-count immediately forces the reset values, asynchronously. The first scan advance after reset release happens SCAN_DIV cycles later.

## Configuration
- Macro: BCD_SCAN_LZ_BLANK_EN.
- **Defined:** leading-zero blanking. While digit i is selected, seg = 0000000 if digit i and every more-significant digit are 0, for i ≥ 1. Digit 0 always displays. The blanking decision uses the same count sample as the displayed value.
- **Undefined:** every digit always displays its value.
- count and wrap are identical in both builds.

## Structure
- Shared package bcd_disp_pkg holds:
  - the ten segment-pattern constants plus SEG_BLANK;
  - a 4-bit BCD digit typedef.
- Sub-module seg7_decode: combinational 4-bit → 7-bit lookup using the package constants, default blank. One instance feeds the seg register.
- Counter, prescaler, scan index and blanking logic live in the top module.

## Test plan
- Reset, DIGITS=4, SCAN_DIV=4 → count=0000, dig_sel=0001, seg=1111110. dig_sel reaches 0010 after 4 cycles and returns to 0001 after 16.
- Load 0x9998, up=1, en high 3 cycles → count 9999, then 0000 with wrap=1 on that edge only, then 0001.
- Load 0x0001, up=0, en high 2 cycles → count 0000, then 9999 with wrap=1. Load 0x0100, one down step → 0099.
- load=1 and en=1 together with load_val=0xF3A2 → count=9392 (clamped), no step, wrap=0.
- Count 0x0070 with the macro defined → digit 3 and digit 2 seg=0000000, digit 1 seg=1110000, digit 0 seg=1111110. Macro undefined → digits 3 and 2 show 1111110.
- Assert rst_n low mid-count at an arbitrary phase → all outputs take reset values without waiting for a clk edge.
